// File: rtl/ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_bus_arbiter
//
// Round-robin AHB bus arbiter with default-master parking. It shares one
// address/data path between NUM_MASTERS requesters, drives the registered
// one-hot grant, and tracks the address-phase and data-phase owner indices
// used by the master-to-slave multiplexers. Ownership never changes in the
// middle of a burst (htrans SEQ/BUSY) or during a wait state (hready low).
//
// Optional feature macro: AHB_ARB_LOCK_EN
//   defined   : hlock is honoured, a locked owner keeps the bus (LOCK state)
//               and hmastlock reports the lock of the address phase.
//   undefined : hlock is ignored, hmastlock is tied to 0, no LOCK state.
//
// Ports
//   hclk          in   bus clock, rising edge
//   hresetn       in   asynchronous active-low reset
//   hbusreq  [N]  in   per-master level-sensitive bus request
//   hlock    [N]  in   per-master lock request
//   htrans   [2]  in   muxed HTRANS of the address-phase owner
//   hready        in   bus HREADY
//   hgrant   [N]  out  registered one-hot grant
//   hmaster  [MW] out  address-phase owner index
//   hmaster_data  out  data-phase owner index
//   hmastlock     out  current address phase is locked
//   dbg_state_o   out  FSM state (0 PARK, 1 OWN, 2 LOCK)
//
// Handshake: a transfer completes on a rising edge where hready = 1. All owner
// registers advance only on such edges; the grant moves only on a completed
// edge whose htrans is IDLE or NONSEQ and the owner is not locked.
// ----------------------------------------------------------------------------
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic [MW-1:0]          hmaster_data,
    output logic                   hmastlock,
    output logic [1:0]             dbg_state_o
);

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1
`ifdef AHB_ARB_LOCK_EN
        ,
        ST_LOCK = 2'd2
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [MW-1:0]          hmaster_q;
    logic [MW-1:0]          hmaster_data_q;

    logic [MW-1:0]          cur_idx;
    logic [MW-1:0]          scan_idx;
    logic [MW-1:0]          win_idx;
    logic                   win_found;
    logic                   rearb;

    // Index of the current (one-hot) grant; this is also the round-robin
    // pointer, so the scan below starts just after the present owner.
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) cur_idx = MW'(i);
        end
    end

    // Scan offsets 1..N so the current owner is visited last: it keeps the
    // bus only when nobody else is asking.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            scan_idx = MW'((int'(cur_idx) + k) % NUM_MASTERS);
            if (!win_found && hbusreq[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // htrans[0] is set for both BUSY (01) and SEQ (11): mid-burst.
    always_comb begin
        rearb = hready && !htrans[0];
`ifdef AHB_ARB_LOCK_EN
        if (state_q == ST_LOCK && hlock[cur_idx]) rearb = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        if (rearb) begin
            if (win_found) begin
                grant_d = NUM_MASTERS'(1) << win_idx;
                state_d = ST_OWN;
`ifdef AHB_ARB_LOCK_EN
                if (hlock[win_idx]) state_d = ST_LOCK;
`endif
            end else begin
                grant_d = NUM_MASTERS'(1);
                state_d = ST_PARK;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_PARK;
            grant_q <= NUM_MASTERS'(1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Address-phase owner follows the grant, data-phase owner follows the
    // address-phase owner; both only on completed transfers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hmaster_q      <= '0;
            hmaster_data_q <= '0;
        end else if (hready) begin
            hmaster_q      <= cur_idx;
            hmaster_data_q <= hmaster_q;
        end
    end

`ifdef AHB_ARB_LOCK_EN
    logic hmastlock_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hmastlock_q <= 1'b0;
        end else if (hready) begin
            hmastlock_q <= hlock[cur_idx];
        end
    end

    assign hmastlock = hmastlock_q;
`else
    logic unused_hlock;
    assign unused_hlock = ^hlock;
    assign hmastlock    = 1'b0;
`endif

    assign hgrant       = grant_q;
    assign hmaster      = hmaster_q;
    assign hmaster_data = hmaster_data_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_bus_arbiter
//
// Directed bench for ahb_bus_arbiter (NUM_MASTERS = 4). Inputs change 1 ns
// after a rising edge and outputs are sampled at that same point, so each
// step() shows the result of exactly one rising edge.
// ----------------------------------------------------------------------------
module tb_ahb_bus_arbiter;

    localparam int N  = 4;
    localparam int MW = 2;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic          hclk;
    logic          hresetn;
    logic [N-1:0]  hbusreq;
    logic [N-1:0]  hlock;
    logic [1:0]    htrans;
    logic          hready;
    logic [N-1:0]  hgrant;
    logic [MW-1:0] hmaster;
    logic [MW-1:0] hmaster_data;
    logic          hmastlock;
    logic [1:0]    dbg_state;

    int n_cmp;
    int n_err;

    // ---------------- clock / reset ----------------
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    ahb_bus_arbiter #(.NUM_MASTERS(N)) dut (
        .hclk         (hclk),
        .hresetn      (hresetn),
        .hbusreq      (hbusreq),
        .hlock        (hlock),
        .htrans       (htrans),
        .hready       (hready),
        .hgrant       (hgrant),
        .hmaster      (hmaster),
        .hmaster_data (hmaster_data),
        .hmastlock    (hmastlock),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp   = 0;
        n_err   = 0;
        hresetn = 1'b0;
        hbusreq = 4'b1111;
        hlock   = 4'b0000;
        htrans  = NONSEQ;
        hready  = 1'b1;

        // Reset held with every master requesting.
        repeat (2) step();
        check("rst_grant", hgrant, 4'b0001);
        check("rst_hmaster", hmaster, 0);
        check("rst_hdata", hmaster_data, 0);
        check("rst_lock", hmastlock, 0);
        check("rst_state", dbg_state, 0);

        // Round-robin with all masters requesting.
        hresetn = 1'b1;
        step();
        check("rr1_grant", hgrant, 4'b0010);
        check("rr1_state", dbg_state, 1);
        step();
        check("rr2_grant", hgrant, 4'b0100);
        check("rr2_hmaster", hmaster, 1);
        check("rr2_hdata", hmaster_data, 0);
        step();
        check("rr3_grant", hgrant, 4'b1000);
        check("rr3_hmaster", hmaster, 2);
        check("rr3_hdata", hmaster_data, 1);
        step();
        check("rr4_grant", hgrant, 4'b0001);
        check("rr4_hmaster", hmaster, 3);
        step();
        check("rr5_grant", hgrant, 4'b0010);
        check("rr5_hmaster", hmaster, 0);
        check("rr5_hdata", hmaster_data, 3);

        // Burst hold: master 1 bursting, master 2 waiting.
        hbusreq = 4'b0110;
        htrans  = SEQ;
        step();
        check("burst1_grant", hgrant, 4'b0010);
        check("burst1_hmaster", hmaster, 1);
        step();
        check("burst2_grant", hgrant, 4'b0010);
        step();
        check("burst3_grant", hgrant, 4'b0010);
        step();
        check("burst4_grant", hgrant, 4'b0010);
        htrans = NONSEQ;
        step();
        check("burst_end_grant", hgrant, 4'b0100);
        check("burst_end_hmaster", hmaster, 1);
        check("burst_end_hdata", hmaster_data, 1);

        // Wait states while master 3 is waiting to take over.
        hbusreq = 4'b1000;
        hready  = 1'b0;
        step();
        check("wait1_grant", hgrant, 4'b0100);
        check("wait1_hmaster", hmaster, 1);
        step();
        check("wait2_grant", hgrant, 4'b0100);
        check("wait2_hdata", hmaster_data, 1);
        step();
        check("wait3_grant", hgrant, 4'b0100);
        check("wait3_hmaster", hmaster, 1);
        check("wait3_hdata", hmaster_data, 1);
        hready = 1'b1;
        step();
        check("wait_rel_grant", hgrant, 4'b1000);
        check("wait_rel_hmaster", hmaster, 2);
        check("wait_rel_hdata", hmaster_data, 1);
        step();
        check("sole_req_grant", hgrant, 4'b1000);
        check("sole_req_hmaster", hmaster, 3);
        check("sole_req_hdata", hmaster_data, 2);

        // Park: requests vanish while master 3 owns with IDLE.
        hbusreq = 4'b0000;
        htrans  = IDLE;
        step();
        check("park_grant", hgrant, 4'b0001);
        check("park_state", dbg_state, 0);
        check("park_hmaster_old", hmaster, 3);
        step();
        check("park_hmaster", hmaster, 0);
        check("park_hdata", hmaster_data, 3);

        // Grant latency from PARK.
        hbusreq = 4'b0100;
        step();
        check("lat_grant", hgrant, 4'b0100);
        check("lat_state", dbg_state, 1);
        step();
        check("lat_hmaster", hmaster, 2);
        check("lat_hdata", hmaster_data, 0);

        // Asynchronous reset mid-cycle, during a wait state.
        hready = 1'b0;
        #3;
        hresetn = 1'b0;
        #1;
        check("async_rst_grant", hgrant, 4'b0001);
        check("async_rst_hmaster", hmaster, 0);
        check("async_rst_hdata", hmaster_data, 0);
        check("async_rst_state", dbg_state, 0);
        step();
        hresetn = 1'b1;
        hready  = 1'b1;

        // Master 2 asks for a locked sequence while master 3 requests.
        hbusreq = 4'b1100;
        hlock   = 4'b0100;
        htrans  = NONSEQ;
        step();
        check("lockA_grant", hgrant, 4'b0100);
`ifdef AHB_ARB_LOCK_EN
        check("lockA_state", dbg_state, 2);
        step();
        check("lockB_grant", hgrant, 4'b0100);
        check("lockB_mastlock", hmastlock, 1);
        check("lockB_hmaster", hmaster, 2);
        step();
        check("lockC_grant", hgrant, 4'b0100);
        check("lockC_mastlock", hmastlock, 1);
        hlock = 4'b0000;
        step();
        check("lockD_grant", hgrant, 4'b1000);
        check("lockD_state", dbg_state, 1);
        check("lockD_mastlock", hmastlock, 0);
`else
        check("nolockA_state", dbg_state, 1);
        step();
        check("nolockB_grant", hgrant, 4'b1000);
        check("nolockB_mastlock", hmastlock, 0);
        check("nolockB_hmaster", hmaster, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
